// File: rtl/dual_dds_da.sv
// Multi-channel DDS driving parallel DACs: phase accumulators, external waveform ROM,
// per-channel mode select, amplitude scaling and a fixed 4-cycle output pipeline.
module dual_dds_da #(
   parameter int CH_NUM  = 2,
   parameter int DATA_W  = 10,
   parameter int ADDR_W  = 10,
   parameter int PHASE_W = 32
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     cfg_wr,
   input  logic [1:0]               cfg_ch,
   input  logic [1:0]               cfg_sel,
   input  logic [PHASE_W-1:0]       cfg_data,
   input  logic                     cfg_update,
   input  logic                     start,
   input  logic                     stop,
   output logic [CH_NUM*ADDR_W-1:0] rom_addr,
   input  logic [CH_NUM*DATA_W-1:0] rom_data,
   output logic                     da_clk,
   output logic [CH_NUM*DATA_W-1:0] da_data,
   output logic                     running
);

   localparam int SW = DATA_W + 12;
   localparam logic [DATA_W-1:0]    MID   = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [SW-1:0] MID_S = SW'({1'b0, MID});
   localparam logic signed [SW-1:0] MAX_S = SW'({1'b0, {DATA_W{1'b1}}});

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t state, state_nx;

   logic [PHASE_W-1:0] ftw_sh   [CH_NUM];
   logic [PHASE_W-1:0] ftw_act  [CH_NUM];
   logic [PHASE_W-1:0] ftw_nx   [CH_NUM];
   logic [ADDR_W-1:0]  poff_sh  [CH_NUM];
   logic [ADDR_W-1:0]  poff_act [CH_NUM];
   logic [ADDR_W-1:0]  poff_nx  [CH_NUM];
   logic [7:0]         amp_sh   [CH_NUM];
   logic [7:0]         amp_act  [CH_NUM];
   logic [7:0]         amp_nx   [CH_NUM];
   logic [1:0]         mode_sh  [CH_NUM];
   logic [1:0]         mode_act [CH_NUM];
   logic [1:0]         mode_nx  [CH_NUM];

   logic [PHASE_W-1:0]    acc       [CH_NUM];
   logic [ADDR_W-1:0]     addr_p1   [CH_NUM];
   logic [ADDR_W-1:0]     addr_p2   [CH_NUM];
   logic signed [SW-1:0]  scaled_p3 [CH_NUM];
   logic [DATA_W-1:0]     out_p4    [CH_NUM];
   logic                  vld_p1, vld_p2;

   function automatic logic [DATA_W-1:0] pick_raw(input logic [1:0] mode,
                                                  input logic [DATA_W-1:0] rom,
                                                  input logic [ADDR_W-1:0] addr);
      logic [ADDR_W+DATA_W-1:0] ext;
      ext = {addr, {DATA_W{1'b0}}};
      case (mode)
         2'd0:    pick_raw = rom;
         2'd1:    pick_raw = ext[ADDR_W+DATA_W-1 -: DATA_W];
         2'd2:    pick_raw = addr[ADDR_W-1] ? '0 : '1;
         default: pick_raw = MID;
      endcase
   endfunction

   function automatic logic signed [SW-1:0] scale(input logic [DATA_W-1:0] raw,
                                                  input logic [7:0] amp);
      logic signed [DATA_W+1:0] diff;
      logic signed [8:0]        gain;
      logic signed [SW-1:0]     prod;
      diff  = $signed({2'b00, raw}) - $signed({2'b00, MID});
      gain  = (amp > 8'd128) ? 9'sd128 : $signed({1'b0, amp});
      prod  = SW'(diff) * SW'(gain);
      scale = MID_S + (prod >>> 7);
   endfunction

   function automatic logic [DATA_W-1:0] clamp(input logic signed [SW-1:0] v);
      if (v < 0)          clamp = '0;
      else if (v > MAX_S) clamp = '1;
      else                clamp = v[DATA_W-1:0];
   endfunction

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nx;
   end

   // stop has priority everywhere; start from RUN re-arms for a phase resync
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!stop && start) state_nx = ARM;
         ARM:     state_nx = stop ? IDLE : RUN;
         RUN:     if (stop) state_nx = IDLE; else if (start) state_nx = ARM;
         default: state_nx = IDLE;
      endcase
   end

   // Shadow next-value includes a same-cycle write so cfg_update copies it too
   always_comb begin
      for (int c = 0; c < CH_NUM; c++) begin
         ftw_nx[c]  = ftw_sh[c];
         poff_nx[c] = poff_sh[c];
         amp_nx[c]  = amp_sh[c];
         mode_nx[c] = mode_sh[c];
         if (cfg_wr && cfg_ch == 2'(c)) begin
            case (cfg_sel)
               2'd0:    ftw_nx[c]  = cfg_data;
               2'd1:    poff_nx[c] = cfg_data[ADDR_W-1:0];
               2'd2:    amp_nx[c]  = cfg_data[7:0];
               default: mode_nx[c] = cfg_data[1:0];
            endcase
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int c = 0; c < CH_NUM; c++) begin
            ftw_sh[c]  <= '0;  ftw_act[c]  <= '0;
            poff_sh[c] <= '0;  poff_act[c] <= '0;
            amp_sh[c]  <= 8'd128; amp_act[c] <= 8'd128;
            mode_sh[c] <= '0;  mode_act[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CH_NUM; c++) begin
            ftw_sh[c]  <= ftw_nx[c];
            poff_sh[c] <= poff_nx[c];
            amp_sh[c]  <= amp_nx[c];
            mode_sh[c] <= mode_nx[c];
            if (cfg_update) begin
               ftw_act[c]  <= ftw_nx[c];
               poff_act[c] <= poff_nx[c];
               amp_act[c]  <= amp_nx[c];
               mode_act[c] <= mode_nx[c];
            end
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         for (int c = 0; c < CH_NUM; c++) begin
            acc[c]       <= '0;
            addr_p1[c]   <= '0;
            addr_p2[c]   <= '0;
            scaled_p3[c] <= MID_S;
            out_p4[c]    <= MID;
         end
      end else begin
         // p1: ROM address; outside RUN it parks on the phase offset
         vld_p1 <= (state == RUN);
         vld_p2 <= vld_p1;
         for (int c = 0; c < CH_NUM; c++) begin
            if (state == ARM)      acc[c] <= '0;
            else if (state == RUN) acc[c] <= acc[c] + ftw_act[c];
            addr_p1[c] <= (state == RUN) ? acc[c][PHASE_W-1 -: ADDR_W] + poff_act[c]
                                         : poff_act[c];
            // p2: address delayed to line up with the synchronous ROM output
            addr_p2[c] <= addr_p1[c];
            // p3: waveform select and amplitude scaling
            scaled_p3[c] <= vld_p2 ? scale(pick_raw(mode_act[c], rom_data[c*DATA_W +: DATA_W],
                                                    addr_p2[c]), amp_act[c])
                                   : MID_S;
            // p4: clamped DAC sample
            out_p4[c] <= clamp(scaled_p3[c]);
         end
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      assign rom_addr[g*ADDR_W +: ADDR_W] = addr_p1[g];
      assign da_data[g*DATA_W +: DATA_W]  = out_p4[g];
   end

   assign da_clk  = ~sys_clk;
   assign running = (state == RUN);

endmodule
